// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and the write-back entry type for the register-file write port
package wb_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

    // One pending register-file write: destination register and the value to write
    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - DEPTH-entry synchronous FIFO of write-back entries
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   push_i, push_data_i write an entry at the tail (caller guarantees !full_o)
//   pop_i               drop the head entry (caller guarantees !empty_o)
//   head_o              current head entry, valid while !empty_o
//   full_o, empty_o     occupancy flags
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  wb_entry_t push_data_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t       mem_q [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     rd_ptr_q;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define which slots are live.
    // A push while full-and-popping overwrites the slot being read, which is
    // safe because the head is consumed from the old contents this cycle.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU and memory-path writes onto the register-file write port
//
// Build option: define WB_BYPASS_EN to let a memory result go straight to the
// write port when the FIFO is empty and the ALU is not writing.
//
// Ports:
//   clk, reset                     clock (rising edge), asynchronous active-low reset
//   alu_valid/alu_reg/alu_data     single-cycle ALU result (no backpressure, held during alu_stall)
//   mem_valid/mem_ready/mem_reg/mem_data  memory result handshake into the FIFO
//   issue_valid/issue_reg          decode issued a memory op writing issue_reg
//   pending_out                    bit r set while a memory-path write to r is outstanding
//   alu_stall                      one-cycle request to hold the ALU result
//   enable/writeReg_out/writeData_out  registered register-file write port
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    input  logic [REG_W-1:0]    alu_reg,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                mem_valid,
    output logic                mem_ready,
    input  logic [REG_W-1:0]    mem_reg,
    input  logic [DATA_W-1:0]   mem_data,
    input  logic                issue_valid,
    input  logic [REG_W-1:0]    issue_reg,
    output logic [NUM_REGS-1:0] pending_out,
    output logic                alu_stall,
    output logic                enable,
    output logic [REG_W-1:0]    writeReg_out,
    output logic [DATA_W-1:0]   writeData_out
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic                enable_q,    enable_d;
    logic [REG_W-1:0]    write_reg_q, write_reg_d;
    logic [DATA_W-1:0]   write_data_q, write_data_d;
    logic [NUM_REGS-1:0] pending_q,   pending_d;
    logic [CW-1:0]       starve_q,    starve_d;
    logic                alu_stall_q, alu_stall_d;

    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_push;
    logic      fifo_pop;
    wb_entry_t fifo_head;
    wb_entry_t mem_entry;
    wb_entry_t sel;
    logic      sel_valid;
    logic      mem_accept;
    logic      alu_win;
    logic      bypass;

    // Held low during reset so no transfer is signalled while the FIFO is cleared
    assign mem_ready  = reset && !fifo_full;
    assign mem_accept = mem_valid && mem_ready;
    assign mem_entry  = '{dst: mem_reg, data: mem_data};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .push_i      (fifo_push),
        .push_data_i (mem_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        alu_win  = alu_valid && !alu_stall_q;
        fifo_pop = !alu_win && !fifo_empty;
`ifdef WB_BYPASS_EN
        bypass   = !alu_win && fifo_empty && mem_accept;
`else
        bypass   = 1'b0;
`endif
        fifo_push = mem_accept && !bypass;

        // Port source in priority order: ALU, FIFO head, bypassed memory result
        sel       = '0;
        sel_valid = 1'b0;
        if (alu_win) begin
            sel       = '{dst: alu_reg, data: alu_data};
            sel_valid = 1'b1;
        end else if (fifo_pop) begin
            sel       = fifo_head;
            sel_valid = 1'b1;
        end else if (bypass) begin
            sel       = mem_entry;
            sel_valid = 1'b1;
        end

        // Writes to register 0 are consumed but never reach the register file
        enable_d     = sel_valid && (sel.dst != ZERO_REG);
        write_reg_d  = sel_valid ? sel.dst  : write_reg_q;
        write_data_d = sel_valid ? sel.data : write_data_q;

        // Clear on retirement first so a same-cycle re-issue of that register wins
        pending_d = pending_q;
        if (fifo_pop || bypass) begin
            pending_d[sel.dst] = 1'b0;
        end
        if (issue_valid && (issue_reg != ZERO_REG)) begin
            pending_d[issue_reg] = 1'b1;
        end

        // Count cycles the queued head loses to the ALU; any pop or an empty FIFO resets it
        starve_d = starve_q;
        if (fifo_pop || fifo_empty) begin
            starve_d = '0;
        end else if (alu_win) begin
            starve_d = starve_q + 1'b1;
        end
        // Reaching the limit forces the head through next cycle, which pops and clears the count
        alu_stall_d = (starve_d == CW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_q     <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            pending_q    <= '0;
            starve_q     <= '0;
            alu_stall_q  <= 1'b0;
        end else begin
            enable_q     <= enable_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            pending_q    <= pending_d;
            starve_q     <= starve_d;
            alu_stall_q  <= alu_stall_d;
        end
    end

    assign enable        = enable_q;
    assign writeReg_out  = write_reg_q;
    assign writeData_out = write_data_q;
    assign pending_out   = pending_q;
    assign alu_stall     = alu_stall_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized scoreboard bench for wb_arbiter
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_reg = '0;
    logic [31:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [4:0]  mem_reg = '0;
    logic [31:0] mem_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_reg = '0;
    logic [31:0] pending_out;
    logic        alu_stall;
    logic        enable;
    logic [4:0]  writeReg_out;
    logic [31:0] writeData_out;

    wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_valid     (alu_valid),
        .alu_reg       (alu_reg),
        .alu_data      (alu_data),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_reg       (mem_reg),
        .mem_data      (mem_data),
        .issue_valid   (issue_valid),
        .issue_reg     (issue_reg),
        .pending_out   (pending_out),
        .alu_stall     (alu_stall),
        .enable        (enable),
        .writeReg_out  (writeReg_out),
        .writeData_out (writeData_out)
    );

    always #5 clk = ~clk;

    typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;
    typedef struct { int cyc; logic [4:0] r; logic [31:0] d; } exp_t;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference model state
    ent_t        m_fifo[$];
    logic [31:0] m_pend = '0;
    int          m_starve = 0;
    bit          m_stall = 1'b0;
    bit          last_av = 1'b0;
    logic [4:0]  last_ar = '0;
    logic [31:0] last_ad = '0;
    exp_t        expq[$];
    logic [4:0]  outst[$];
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Write-port monitor: each enable must match the next expected write in order and cycle
    always @(negedge clk) begin
        if (enable === 1'b1) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got reg %0d data %h, expected no write (cycle %0d)",
                         writeReg_out, writeData_out, cyc);
            end else begin
                mon_e = expq.pop_front();
                chk("write_cycle", cyc, mon_e.cyc);
                chk("write_reg", {27'b0, writeReg_out}, {27'b0, mon_e.r});
                chk("write_data", writeData_out, mon_e.d);
            end
        end else if (expq.size() > 0 && expq[0].cyc <= cyc) begin
            mon_e = expq.pop_front();
            tests++;
            fails++;
            $display("FAIL missing_write: got enable 0, expected reg %0d data %h at cycle %0d",
                     mon_e.r, mon_e.d, mon_e.cyc);
        end
    end

    // One clock of stimulus: check visible state against the model, drive, advance the model
    task automatic step(input bit av_in, input logic [4:0] ar_in, input logic [31:0] ad_in,
                        input bit mv, input logic [4:0] mr, input logic [31:0] md,
                        input bit iv, input logic [4:0] ir, output bit acc);
        bit av;
        logic [4:0] ar;
        logic [31:0] ad;
        bit alu_win, popped, byp, have;
        ent_t o;
        exp_t x;
        int sz;
        av = av_in; ar = ar_in; ad = ad_in;
        @(negedge clk);
        #1;
        chk("mem_ready", {31'b0, mem_ready}, {31'b0, m_fifo.size() < DEPTH});
        chk("alu_stall", {31'b0, alu_stall}, {31'b0, m_stall});
        chk("pending", pending_out, m_pend);
        if (m_stall && last_av) begin
            av = 1'b1; ar = last_ar; ad = last_ad;
        end
        alu_valid = av; alu_reg = ar; alu_data = ad;
        mem_valid = mv; mem_reg = mr; mem_data = md;
        issue_valid = iv; issue_reg = ir;

        sz = m_fifo.size();
        acc = mv && (sz < DEPTH);
        alu_win = av && !m_stall;
        popped = 1'b0; byp = 1'b0; have = 1'b0;
        o.r = '0; o.d = '0;
        if (alu_win) begin
            o.r = ar; o.d = ad; have = 1'b1;
        end else if (sz > 0) begin
            o = m_fifo.pop_front(); have = 1'b1; popped = 1'b1;
        end
`ifdef WB_BYPASS_EN
        else if (acc) begin
            o.r = mr; o.d = md; have = 1'b1; byp = 1'b1;
        end
`endif
        if (have && o.r != 5'd0) begin
            x.cyc = cyc + 1; x.r = o.r; x.d = o.d;
            expq.push_back(x);
        end
        if (iv && ir != 5'd0 && m_pend[ir] && !((popped || byp) && o.r == ir)) begin
            tests++;
            fails++;
            $display("FAIL issue_legal: got issue to pending reg %0d, expected none", ir);
        end
        if (popped || byp) m_pend[o.r] = 1'b0;
        if (iv && ir != 5'd0) m_pend[ir] = 1'b1;
        if (acc && !byp) begin
            ent_t n;
            n.r = mr; n.d = md;
            m_fifo.push_back(n);
        end
        if (popped || sz == 0) m_starve = 0;
        else if (alu_win) m_starve++;
        m_stall = (m_starve == LIMIT);
        last_av = av; last_ar = ar; last_ad = ad;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, a);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_enable", {31'b0, enable}, 32'd0);
        chk("rst_write_reg", {27'b0, writeReg_out}, 32'd0);
        chk("rst_write_data", writeData_out, 32'd0);
        chk("rst_pending", pending_out, 32'd0);
        chk("rst_alu_stall", {31'b0, alu_stall}, 32'd0);
        chk("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
        m_fifo.delete(); expq.delete(); outst.delete();
        m_pend = '0; m_starve = 0; m_stall = 1'b0; last_av = 1'b0;
        alu_valid = 0; mem_valid = 0; issue_valid = 0;
        repeat (hold) @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        bit a;
        // Power-on reset
        repeat (2) @(negedge clk);
        #1;
        chk("por_enable", {31'b0, enable}, 32'd0);
        chk("por_write_reg", {27'b0, writeReg_out}, 32'd0);
        chk("por_write_data", writeData_out, 32'd0);
        chk("por_pending", pending_out, 32'd0);
        chk("por_alu_stall", {31'b0, alu_stall}, 32'd0);
        reset = 1'b1;

        // ALU single write
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, a);
        idle(2);

        // Issue then memory result with ALU idle
        step(0, 0, 0, 0, 0, 0, 1, 8, a);
        step(0, 0, 0, 1, 8, 32'h1234, 0, 0, a);
        idle(3);

        // Fill FIFO behind a continuously valid ALU, then drain with stall pulses
        for (int r = 20; r < 24; r++) step(0, 0, 0, 0, 0, 0, 1, 5'(r), a);
        for (int r = 20; r < 24; r++) step(1, 5'(r - 19), $urandom, 1, 5'(r), 32'h100 + r, 0, 0, a);
        for (int i = 0; i < 12; i++) step(1, 5'(i + 1), $urandom, 0, 0, 0, 0, 0, a);
        idle(3);

        // Register 0 writes from both sources
        step(1, 0, 32'hAAAA0000, 0, 0, 0, 0, 0, a);
        step(0, 0, 0, 1, 0, 32'hBBBB0000, 0, 0, a);
        idle(3);

        // Re-issue of reg 3 in the cycle its memory write retires
        step(0, 0, 0, 0, 0, 0, 1, 3, a);
        step(0, 0, 0, 1, 3, 32'h33, 0, 0, a);
        step(0, 0, 0, 0, 0, 0, 1, 3, a);
        idle(3);
        step(0, 0, 0, 1, 3, 32'h333, 0, 0, a);
        idle(3);

        // Reset with three queued entries and pending bits set
        for (int r = 10; r < 13; r++) step(0, 0, 0, 0, 0, 0, 1, 5'(r), a);
        for (int r = 10; r < 13; r++) step(1, 5'(r - 9), $urandom, 1, 5'(r), $urandom, 0, 0, a);
        do_reset(2);
        idle(6);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            bit av, mv, iv, acc;
            logic [4:0] ar, mr, ir;
            logic [31:0] ad, md;
            av = ($urandom_range(0, 99) < 55);
            ar = 5'($urandom_range(0, 31));
            ad = $urandom;
            mv = 1'b0; mr = '0; md = $urandom;
            if (outst.size() > 0 && $urandom_range(0, 99) < 60) begin
                mv = 1'b1; mr = outst[0];
            end else if ($urandom_range(0, 99) < 4) begin
                mv = 1'b1;
            end
            iv = 1'b0; ir = '0;
            if ($urandom_range(0, 99) < 35) begin
                ir = 5'($urandom_range(0, 31));
                if (ir == 5'd0 || !m_pend[ir]) iv = 1'b1;
                else ir = '0;
            end
            step(av, ar, ad, mv, mr, md, iv, ir, acc);
            if (acc && mr != 5'd0) void'(outst.pop_front());
            if (iv && ir != 5'd0) outst.push_back(ir);
        end

        // Drain and confirm every expected write appeared
        idle(DEPTH * 4 + 8);
        @(negedge clk);
        #1;
        chk("drain_empty", expq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
